// File: rtl/mtl2_timing_gen_if.sv
// Video-side bundle of the MTL2 panel timing generator:
// upstream pixel request/data and the registered panel outputs.
interface mtl2_timing_gen_if;
    logic [23:0] rgb_in;
    logic        pixel_req;
    logic [23:0] rgb_out;
    logic        hsync_n;
    logic        vsync_n;
    logic        de;
    logic [10:0] x;
    logic [9:0]  y;
    logic        frame_start;

    modport master (
        input  rgb_in,
        output pixel_req, rgb_out, hsync_n, vsync_n, de, x, y, frame_start
    );

    modport slave (
        output rgb_in,
        input  pixel_req, rgb_out, hsync_n, vsync_n, de, x, y, frame_start
    );
endinterface

// File: rtl/mtl2_timing_gen.sv
// MTL2 panel timing generator: waits for PLL lock, settles, then scans
// h/v counters. Define MTL2_TG_PATTERN_EN for built-in 8-colour bars.
module mtl2_timing_gen #(
    parameter int H_ACTIVE   = 800,
    parameter int H_FP       = 40,
    parameter int H_SYNC     = 48,
    parameter int H_BP       = 168,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 13,
    parameter int V_SYNC     = 3,
    parameter int V_BP       = 29,
    parameter int SETTLE_CYC = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              locked,
    mtl2_timing_gen_if.master vid
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int SW      = $clog2(SETTLE_CYC + 1);

    localparam logic [10:0] H_ACT_L = 11'(H_ACTIVE);
    localparam logic [10:0] H_SS_L  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SE_L  = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
    localparam logic [9:0]  V_ACT_L = 10'(V_ACTIVE);
    localparam logic [9:0]  V_SS_L  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  V_SE_L  = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [SW-1:0] S_LAST = SW'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        RUN       = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [10:0]   h_q, h_d;
    logic [9:0]    v_q, v_d;

    logic        run_ok;
    logic        act;
    logic        de_d, hs_d, vs_d, fs_d;
    logic [10:0] x_d;
    logic [9:0]  y_d;
    logic [23:0] pix;
    logic [23:0] rgb_d;

    logic        de_q, hs_q, vs_q, fs_q;
    logic [10:0] x_q;
    logic [9:0]  y_q;
    logic [23:0] rgb_q;

    // State, settle count and scan counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= WAIT_LOCK;
            settle_q <= '0;
            h_q      <= '0;
            v_q      <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            h_q      <= h_d;
            v_q      <= v_d;
        end
    end

    // Next state: counters only advance while running and locked
    always_comb begin
        state_d  = state_q;
        settle_d = '0;
        h_d      = '0;
        v_d      = '0;
        unique case (state_q)
            WAIT_LOCK: begin
                if (locked) state_d = SETTLE;
            end
            SETTLE: begin
                if (!locked) begin
                    state_d = WAIT_LOCK;
                end else if (settle_q == S_LAST) begin
                    state_d = RUN;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            RUN: begin
                if (!locked) begin
                    state_d = WAIT_LOCK;
                end else if (h_q == H_LAST) begin
                    h_d = '0;
                    v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
                end else begin
                    h_d = h_q + 1'b1;
                    v_d = v_q;
                end
            end
            default: state_d = WAIT_LOCK;
        endcase
    end

`ifdef MTL2_TG_PATTERN_EN
    logic       unused_rgb;
    logic [2:0] bar;

    assign unused_rgb = ^vid.rgb_in;

    // Colour bars, 100 px wide, white..black left to right
    always_comb begin
        bar = 3'd7;
        if (h_q < 11'd100)      bar = 3'd0;
        else if (h_q < 11'd200) bar = 3'd1;
        else if (h_q < 11'd300) bar = 3'd2;
        else if (h_q < 11'd400) bar = 3'd3;
        else if (h_q < 11'd500) bar = 3'd4;
        else if (h_q < 11'd600) bar = 3'd5;
        else if (h_q < 11'd700) bar = 3'd6;
        pix = 24'h000000;
        unique case (bar)
            3'd0: pix = 24'hFFFFFF;
            3'd1: pix = 24'hFFFF00;
            3'd2: pix = 24'h00FFFF;
            3'd3: pix = 24'h00FF00;
            3'd4: pix = 24'hFF00FF;
            3'd5: pix = 24'hFF0000;
            3'd6: pix = 24'h0000FF;
            default: pix = 24'h000000;
        endcase
    end
`else
    assign pix = vid.rgb_in;
`endif

    // Output decode; a lock drop blanks the very next output cycle
    always_comb begin
        run_ok = (state_q == RUN) && locked;
        act    = (h_q < H_ACT_L) && (v_q < V_ACT_L);
        de_d   = run_ok && act;
        hs_d   = !(run_ok && (h_q >= H_SS_L) && (h_q < H_SE_L));
        vs_d   = !(run_ok && (v_q >= V_SS_L) && (v_q < V_SE_L));
        x_d    = de_d ? h_q : '0;
        y_d    = de_d ? v_q : '0;
        rgb_d  = de_d ? pix : '0;
        fs_d   = de_d && (h_q == '0) && (v_q == '0);
    end

    // Registered panel outputs, one cycle behind pixel_req
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            de_q  <= 1'b0;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
            x_q   <= '0;
            y_q   <= '0;
            rgb_q <= '0;
            fs_q  <= 1'b0;
        end else begin
            de_q  <= de_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            x_q   <= x_d;
            y_q   <= y_d;
            rgb_q <= rgb_d;
            fs_q  <= fs_d;
        end
    end

    assign vid.pixel_req   = (state_q == RUN) && act;
    assign vid.de          = de_q;
    assign vid.hsync_n     = hs_q;
    assign vid.vsync_n     = vs_q;
    assign vid.x           = x_q;
    assign vid.y           = y_q;
    assign vid.rgb_out     = rgb_q;
    assign vid.frame_start = fs_q;
endmodule

// File: tb/tb_mtl2_timing_gen.sv
// Bench for mtl2_timing_gen: reference model on a running pixel index,
// plus directed lock/reset scenarios with literal expectations.
module tb_mtl2_timing_gen;
    localparam int HA = 800, HF = 40, HS = 48, HB = 168;
    localparam int VA = 12, VF = 2, VS = 3, VB = 3;
    localparam int SC = 16;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FR = HT * VT;

    logic clk = 1'b0;
    logic rst_n;
    logic locked;

    mtl2_timing_gen_if vif();

    mtl2_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SETTLE_CYC(SC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .locked(locked),
        .vid(vif)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // model: mode 0 waiting, 1 settling, 2 scanning pixel index m_t
    int m_mode = 0, m_streak = 0, m_t = 0;
    int m_h = 0, m_v = 0;
    bit e_de = 0, e_hs = 1, e_vs = 1, e_fs = 0, e_req = 0;
    int e_x = 0, e_y = 0;
    logic [23:0] e_rgb = '0;

    function automatic logic [23:0] bar_rgb(input int h);
        logic [23:0] tbl [8];
        tbl = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        return tbl[(h / 100 > 7) ? 7 : h / 100];
    endfunction

    always @(posedge clk) begin
        int h, v;
        bit run;
        if (!rst_n) begin
            m_mode = 0; m_streak = 0; m_t = 0;
            e_de = 0; e_hs = 1; e_vs = 1; e_fs = 0;
            e_x = 0; e_y = 0; e_rgb = '0;
        end else begin
            run  = (m_mode == 2) && locked;
            h    = m_t % HT;
            v    = (m_t / HT) % VT;
            e_de = run && h < HA && v < VA;
            e_hs = !(run && h >= HA + HF && h < HA + HF + HS);
            e_vs = !(run && v >= VA + VF && v < VA + VF + VS);
            e_x  = e_de ? h : 0;
            e_y  = e_de ? v : 0;
`ifdef MTL2_TG_PATTERN_EN
            e_rgb = e_de ? bar_rgb(h) : 24'h0;
`else
            e_rgb = e_de ? vif.rgb_in : 24'h0;
`endif
            e_fs = e_de && h == 0 && v == 0;
            case (m_mode)
                0: if (locked) begin m_mode = 1; m_streak = 0; end
                1: if (!locked) m_mode = 0;
                   else begin
                       m_streak++;
                       if (m_streak == SC) begin m_mode = 2; m_t = 0; end
                   end
                default: if (locked) m_t++; else m_mode = 0;
            endcase
        end
        m_h   = m_t % HT;
        m_v   = (m_t / HT) % VT;
        e_req = (m_mode == 2) && m_h < HA && m_v < VA;
    end

    // upstream source: {x,y,A5} while requested, junk otherwise
    always @(negedge clk) begin
        logic [10:0] hh;
        logic [9:0]  vv;
        hh = 11'(m_h);
        vv = 10'(m_v);
        vif.rgb_in = e_req ? {hh[7:0], vv[7:0], 8'hA5} : 24'h5A5A5A;
    end

    // cycle-by-cycle compare against the model
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if ({vif.de, vif.hsync_n, vif.vsync_n, vif.frame_start,
                 vif.pixel_req, vif.x, vif.y, vif.rgb_out} !==
                {e_de, e_hs, e_vs, e_fs, e_req, 11'(e_x), 10'(e_y), e_rgb}) begin
                errors++;
                if (errors <= 20)
                    $display("FAIL model t=%0t de/hs/vs/fs/req=%b%b%b%b%b x=%0d y=%0d rgb=%h required %b%b%b%b%b x=%0d y=%0d rgb=%h",
                             $time, vif.de, vif.hsync_n, vif.vsync_n, vif.frame_start,
                             vif.pixel_req, vif.x, vif.y, vif.rgb_out,
                             e_de, e_hs, e_vs, e_fs, e_req, e_x, e_y, e_rgb);
            end
`ifdef MTL2_TG_PATTERN_EN
            if (e_de && (e_x == 0 || e_x == 150 || e_x == 799) && e_y == 0) begin
                logic [23:0] lit;
                lit = (e_x == 0) ? 24'hFFFFFF : (e_x == 150) ? 24'hFFFF00 : 24'h000000;
                checks++;
                if (vif.rgb_out !== lit) begin
                    errors++;
                    $display("FAIL pattern x=%0d got %h required %h", e_x, vif.rgb_out, lit);
                end
            end
`endif
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic wait_req(output int n);
        bit found = 0;
        n = 0;
        while (!found && n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (vif.pixel_req === 1'b1) found = 1;
        end
    endtask

    task automatic chk_origin(input string tag);
        @(negedge clk);
        chk({tag, "_fs"}, 32'(vif.frame_start), 1);
        chk({tag, "_de"}, 32'(vif.de), 1);
        chk({tag, "_x"}, 32'(vif.x), 0);
        chk({tag, "_y"}, 32'(vif.y), 0);
    endtask

    initial begin
        int n, de_n, hs_n, vs_n, fs_n, hs_run, vs_run;
        int hs_min, hs_max, vs_max, hs_falls;
        bit prev_hs, found;
        rst_n  = 1'b0;
        locked = 1'b1;
        vif.rgb_in = '0;
        repeat (3) @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_de", 32'(vif.de), 0);
        chk("rst_hs", 32'(vif.hsync_n), 1);
        chk("rst_vs", 32'(vif.vsync_n), 1);
        chk("rst_xy", 32'({vif.x, vif.y}), 0);
        chk("rst_rgb", 32'(vif.rgb_out), 0);
        chk("rst_fs", 32'(vif.frame_start), 0);
        chk("rst_req", 32'(vif.pixel_req), 0);

        rst_n = 1'b1;
        wait_req(n);
        chk("first_req_lat", n, SC + 1);
        chk_origin("first");

        de_n = 0; hs_n = 0; vs_n = 0; fs_n = 0;
        hs_run = 0; vs_run = 0; hs_min = 1 << 30; hs_max = 0; vs_max = 0;
        hs_falls = 0; prev_hs = 1'b1;
        for (int i = 0; i < 2 * FR; i++) begin
            if (i > 0) @(negedge clk);
            de_n += int'(vif.de);
            fs_n += int'(vif.frame_start);
            if (!vif.hsync_n) begin
                hs_n++; hs_run++;
                if (prev_hs) hs_falls++;
            end else if (hs_run > 0) begin
                if (hs_run < hs_min) hs_min = hs_run;
                if (hs_run > hs_max) hs_max = hs_run;
                hs_run = 0;
            end
            if (!vif.vsync_n) begin
                vs_n++; vs_run++;
            end else if (vs_run > 0) begin
                if (vs_run > vs_max) vs_max = vs_run;
                vs_run = 0;
            end
            prev_hs = vif.hsync_n;
        end
        chk("de_cycles_2fr", de_n, 2 * 12 * 800);
        chk("hs_low_2fr", hs_n, 2 * 20 * 48);
        chk("vs_low_2fr", vs_n, 2 * 3 * 1056);
        chk("hs_pulses", hs_falls, 40);
        chk("hs_run_min", hs_min, 48);
        chk("hs_run_max", hs_max, 48);
        chk("vs_run_max", vs_max, 3168);
        chk("fs_count", fs_n, 2);

        found = 0;
        for (int i = 0; i < FR + 10 && !found; i++) begin
            @(negedge clk);
            if (m_mode == 2 && m_t % FR == 5 * HT + 400) found = 1;
        end
        chk("drop_found", 32'(found), 1);
        locked = 1'b0;
        @(negedge clk);
        chk("drop_de", 32'(vif.de), 0);
        chk("drop_req", 32'(vif.pixel_req), 0);
        chk("drop_hs", 32'(vif.hsync_n), 1);
        chk("drop_vs", 32'(vif.vsync_n), 1);
        repeat (3) @(negedge clk);
        locked = 1'b1;
        wait_req(n);
        chk("relock_lat", n, SC + 1);
        chk_origin("relock");

        locked = 1'b0;
        repeat (2) @(negedge clk);
        locked = 1'b1;
        repeat (6) @(negedge clk);
        locked = 1'b0;
        @(negedge clk);
        locked = 1'b1;
        wait_req(n);
        chk("glitch_lat", n + 7, 24);
        chk_origin("glitch");

        repeat (50) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mtl2_timing_gen.md
MTL2_TIMING_GEN -- requirements
Module: mtl2_timing_gen

Interface
REQ-001 SHALL have parameters H_ACTIVE 800, H_FP 40, H_SYNC 48, H_BP 168 (pixels); V_ACTIVE 480, V_FP 13, V_SYNC 3, V_BP 29 (lines); SETTLE_CYC 16.
REQ-002 SHALL have port clk, input, 1: 33.29 MHz pixel clock from the display PLL; the only clock.
REQ-003 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-004 SHALL have port locked, input, 1: PLL lock, synchronous to clk.
REQ-005 SHALL have port rgb_in, input, 24: upstream pixel {R,G,B}, valid in the cycle pixel_req=1.
REQ-006 SHALL have port pixel_req, output, 1: requests one pixel from upstream this cycle.
REQ-007 SHALL have port rgb_out, output, 24: pixel to panel, aligned with de.
REQ-008 SHALL have ports hsync_n, vsync_n, de, output, 1 each: panel sync (active-low) and data enable.
REQ-009 SHALL have ports x, output, 11 and y, output, 10: coordinates of the pixel on rgb_out.
REQ-010 SHALL have port frame_start, output, 1: one-cycle pulse with first active pixel of each frame on de.

Function
REQ-011 SHALL run FSM WAIT_LOCK -> SETTLE -> RUN.
REQ-012 WAIT_LOCK: counters held at 0; moves to SETTLE when locked=1.
REQ-013 SETTLE: counts locked=1 cycles; after SETTLE_CYC consecutive cycles moves to RUN with h_cnt=0, v_cnt=0; locked=0 returns to WAIT_LOCK, count cleared.
REQ-014 RUN: locked=0 in any cycle SHALL return to WAIT_LOCK next cycle, mid-line or mid-frame, zeroing counters.
REQ-015 h_cnt SHALL count 0..1055 in RUN, wrapping to 0; v_cnt SHALL increment when h_cnt wraps, counting 0..524 and wrapping to 0.
REQ-016 Horizontal regions: active 0..799, front porch 800..839, sync 840..887, back porch 888..1055; vertical: active 0..479, FP 480..492, sync 493..495, BP 496..524.
REQ-017 pixel_req SHALL be combinational: 1 iff state=RUN and h_cnt<800 and v_cnt<480.
REQ-018 de, hsync_n, vsync_n, x, y SHALL be registered from the current counters: one-cycle latency after pixel_req.
REQ-019 rgb_out SHALL register rgb_in when pixel_req=1, else load 0; rgb_out=0 whenever de=0.
REQ-020 hsync_n=0 iff registered h in sync region; vsync_n=0 iff registered v in sync region (full lines, h-independent).
REQ-021 x,y SHALL equal registered h_cnt,v_cnt when de=1, else hold 0.
REQ-022 frame_start SHALL be 1 exactly when de=1, x=0, y=0.
REQ-023 Frame period SHALL be 1056*525=554400 cycles (60.05 Hz).
REQ-024 Leaving RUN: next cycle de=0, hsync_n=1, vsync_n=1, pixel_req=0.

Reset
REQ-025 rst_n=0 at a clk edge SHALL force WAIT_LOCK, counters and settle count 0, de=0, hsync_n=1, vsync_n=1, x=0, y=0, rgb_out=0, frame_start=0; pixel_req=0 combinationally.
REQ-026 Reset SHALL take priority over locked in the same cycle.

Configuration
REQ-027 Macro MTL2_TG_PATTERN_EN defined: rgb_in ignored; rgb_out SHALL be 8 vertical colour bars, 100 px each, left to right white, yellow, cyan, green, magenta, red, blue, black (components 0xFF/0x00); pixel_req still driven.
REQ-028 Macro undefined: rgb_out SHALL follow REQ-019.

Verification
REQ-029 Reset, locked=1 constant -> first pixel_req exactly SETTLE_CYC+1 cycles after rst_n rises; frame_start one cycle later, x=0, y=0.
REQ-030 Free run two frames -> hsync_n low 48 cycles every 1056; vsync_n low 3168 cycles every 554400; 384000 de cycles per frame.
REQ-031 rgb_in = {x[7:0],y[7:0],8'hA5} model -> rgb_out matches pixel at (x,y) every de cycle; rgb_out=0 while de=0.
REQ-032 Drop locked at h_cnt=400, v_cnt=200 -> next cycle de=0, pixel_req=0, syncs high; relock -> SETTLE, restart at (0,0).
REQ-033 locked glitch low for 1 cycle during SETTLE -> settle count restarts; RUN entry delayed accordingly.
REQ-034 With MTL2_TG_PATTERN_EN: x=0 -> 0xFFFFFF, x=150 -> 0xFFFF00, x=799 -> 0x000000.
